uart_frame_tx: RTL and testbench

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 50 +++++
 rtl/uart_frame_tx.sv | 183 ++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART frame transmitter:
//     - uart_state_e    : transmitter FSM state encoding
//     - UART_DATA_BITS  : payload bits per UART character (8N1)
//     - UART_FRAME_BITS : line bits per character (start + 8 data + stop)
//   No ports; imported by uart_frame_tx and uart_baud_gen.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  // Line state of the transmitter. IDLE is the only state in which tx is
  // released high and busy is low.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Bit-period counter. Counts clk cycles and pulses tick on the last cycle of
//   every CLK_DIV-cycle bit period. The counter reloads itself on each tick,
//   so consecutive bits are back to back with no slip. clear holds the count
//   at zero, so the first tick after clear drops arrives CLK_DIV cycles after
//   the edge that released it.
//
//   Ports:
//     clk   in  1  rising-edge clock
//     rst   in  1  synchronous active-high reset
//     clear in  1  hold counter at zero (suppresses tick)
//     tick  out 1  one-cycle pulse marking the last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  // Counter runs 0 .. CLK_DIV-1, which always fits in $clog2(CLK_DIV) bits
  // for CLK_DIV >= 2.
  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST) && !clear;
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
//   Sends a frame of NUM_BYTES bytes as consecutive 8N1 UART characters,
//   least-significant byte first and each byte LSB first, with no idle gap
//   between characters. Each line bit lasts CLK_DIV clk cycles, so a frame
//   occupies NUM_BYTES*10*CLK_DIV cycles.
//
//   Handshake: start is a one-cycle request that is taken only when busy is
//   low (and rst is low). On the accepting edge the payload is captured, busy
//   rises and tx drops for the start bit. A request seen while busy is
//   dropped, not queued. done pulses in the first idle cycle after a frame;
//   a start in that same cycle is accepted, giving zero-gap back-to-back
//   frames. rst aborts a frame immediately without a done pulse.
//
//   Parameters:
//     CLK_DIV   clk cycles per UART bit, 2..65535
//     NUM_BYTES bytes per frame, 1..16
//
//   Ports:
//     clk     in  1            rising-edge clock
//     rst     in  1            synchronous active-high reset
//     start   in  1            frame request pulse
//     data_in in  8*NUM_BYTES  payload, sampled on an accepted start
//     tx      out 1            serial line, idle high
//     busy    out 1            frame in progress
//     done    out 1            one-cycle frame-complete pulse
// -----------------------------------------------------------------------------
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 8,
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] data_in,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int                 SW        = 8 * NUM_BYTES;
  localparam int                 BITW      = $clog2(UART_DATA_BITS);
  localparam int                 BYTEW     = $clog2(NUM_BYTES + 1);
  localparam logic [BITW-1:0]    LAST_BIT  = BITW'(UART_DATA_BITS - 1);
  localparam logic [BYTEW-1:0]   LAST_BYTE = BYTEW'(NUM_BYTES - 1);

  uart_state_e       state_q;
  uart_state_e       state_d;
  logic [SW-1:0]     shift_q;
  logic [SW-1:0]     shift_d;
  logic [BITW-1:0]   bit_cnt_q;
  logic [BITW-1:0]   bit_cnt_d;
  logic [BYTEW-1:0]  byte_cnt_q;
  logic [BYTEW-1:0]  byte_cnt_d;
  logic              done_q;
  logic              done_d;

  logic              baud_clear;
  logic              baud_tick;
  logic              last_byte;

  // The bit timer is parked at zero while idle; because the accepting edge
  // is also the edge that leaves IDLE, the start bit gets a full period.
  assign baud_clear = (state_q == IDLE);
  assign last_byte  = (byte_cnt_q == LAST_BYTE);

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  // ---------------------------------------------------------------------------
  // State register (FSM state plus the datapath it sequences)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START_BIT;
        end
      end
      START_BIT: begin
        if (baud_tick) begin
          state_d = DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (baud_tick && (bit_cnt_q == LAST_BIT)) begin
          state_d = STOP_BIT;
        end
      end
      STOP_BIT: begin
        if (baud_tick) begin
          state_d = last_byte ? IDLE : START_BIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. The shift register moves right one place per data
  // bit, so after eight shifts the next byte's LSB is already at bit 0.
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = data_in;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      START_BIT: begin
        bit_cnt_d = '0;
      end
      DATA_BITS: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
        end
      end
      STOP_BIT: begin
        if (baud_tick) begin
          if (last_byte) begin
            done_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (decoded from registered state only, so tx/busy/done are
  // glitch-free with respect to the inputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    tx   = 1'b1;
    busy = (state_q != IDLE);
    done = done_q;
    unique case (state_q)
      IDLE:      tx = 1'b1;
      START_BIT: tx = 1'b0;
      DATA_BITS: tx = shift_q[0];
      STOP_BIT:  tx = 1'b1;
      default:   tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
module tb_uart_frame_tx;

  // Lane 0: CLK_DIV=4  NUM_BYTES=2   (main scenarios)
  // Lane 1: CLK_DIV=2  NUM_BYTES=1   (smallest frame)
  // Lane 2: CLK_DIV=4  NUM_BYTES=4   (periodic timer pulses)
  // Lane 3: CLK_DIV=3  NUM_BYTES=16  (widest payload, byte order)
  localparam int LANES = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [LANES-1:0] rst_s;
  logic [LANES-1:0] start_s;
  logic [LANES-1:0] tx_w;
  logic [LANES-1:0] busy_w;
  logic [LANES-1:0] done_w;
  logic [127:0]     din_s [LANES];

  int total = 0;
  int bad   = 0;
  int done_cnt [LANES] = '{default: 0};
  logic tx_log [0:1023];

  task automatic check(input string name, input int lane,
                       input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s lane%0d got=%0h want=%0h at %0t", name, lane, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // DUT lanes, each with its own reference model and per-cycle compare
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int CD = (g == 1) ? 2 : (g == 3) ? 3 : 4;
    localparam int NB = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 16;

    uart_frame_tx #(
      .CLK_DIV   (CD),
      .NUM_BYTES (NB)
    ) u_dut (
      .clk     (clk),
      .rst     (rst_s[g]),
      .start   (start_s[g]),
      .data_in (din_s[g][8*NB-1:0]),
      .tx      (tx_w[g]),
      .busy    (busy_w[g]),
      .done    (done_w[g])
    );

    // exp_q holds the line level for every remaining cycle of the frame in
    // flight; head of queue is the level for the current cycle.
    logic exp_q[$];
    logic exp_done = 1'b0;

    always @(posedge clk) begin
      logic was_busy;
      logic v;
      if (rst_s[g]) begin
        exp_q.delete();
        exp_done = 1'b0;
      end else begin
        was_busy = (exp_q.size() != 0);
        if (was_busy) void'(exp_q.pop_front());
        exp_done = was_busy && (exp_q.size() == 0);
        if (start_s[g] && !was_busy) begin
          for (int b = 0; b < NB; b++) begin
            for (int f = 0; f < 10; f++) begin
              if (f == 0)      v = 1'b0;
              else if (f == 9) v = 1'b1;
              else             v = din_s[g][8*b + f - 1];
              for (int c = 0; c < CD; c++) exp_q.push_back(v);
            end
          end
        end
      end
    end

    always @(negedge clk) begin
      logic e_tx;
      logic e_busy;
      e_busy = (exp_q.size() != 0);
      e_tx   = e_busy ? exp_q[0] : 1'b1;
      check("tx", g, 32'(tx_w[g]), 32'(e_tx));
      check("busy", g, 32'(busy_w[g]), 32'(e_busy));
      check("done", g, 32'(done_w[g]), 32'(exp_done));
      if (done_w[g] === 1'b1) done_cnt[g]++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic pulse_start(input int lane, input logic [127:0] data);
    din_s[lane]   = data;
    start_s[lane] = 1'b1;
    @(negedge clk);
    start_s[lane] = 1'b0;
  endtask

  task automatic wait_done(input int lane, input int budget);
    int n = 0;
    while (done_w[lane] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", lane, 32'(done_w[lane]), 32'd1);
  endtask

  // Starts a frame and records tx/busy/done for cycles 1..budget, where
  // cycle 1 is the first cycle after the accepting edge.
  task automatic run_frame(input int lane, input logic [127:0] data, input int budget,
                           output int busy_n, output int done_at);
    busy_n  = 0;
    done_at = 0;
    pulse_start(lane, data);
    for (int c = 1; c <= budget; c++) begin
      tx_log[c] = tx_w[lane];
      if (busy_w[lane] === 1'b1) busy_n++;
      if (done_w[lane] === 1'b1 && done_at == 0) done_at = c;
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int busy_n;
    int done_at;
    int d0;
    logic [19:0] seen;
    logic [127:0] ramp;

    rst_s   = '1;
    start_s = '0;
    for (int k = 0; k < LANES; k++) din_s[k] = '0;
    repeat (3) @(negedge clk);
    start_s = '1;  // requests during reset must be ignored
    @(negedge clk);
    start_s = '0;
    for (int k = 0; k < LANES; k++) begin
      check("rst_tx", k, 32'(tx_w[k]), 32'd1);
      check("rst_busy", k, 32'(busy_w[k]), 32'd0);
      check("rst_done", k, 32'(done_w[k]), 32'd0);
    end
    rst_s = '0;
    repeat (2) @(negedge clk);

    // Single A55A frame, with ignored FFFF requests sprinkled through it.
    d0 = done_cnt[0];
    pulse_start(0, 128'hA55A);
    seen = '0; busy_n = 0; done_at = 0;
    for (int c = 1; c <= 90; c++) begin
      if (busy_w[0] === 1'b1) busy_n++;
      if (done_w[0] === 1'b1 && done_at == 0) done_at = c;
      if (c <= 80 && ((c - 1) % 4) == 2) seen[(c - 1) / 4] = tx_w[0];
      if (c == 10 || c == 30 || c == 50) begin
        start_s[0] = 1'b1;
        din_s[0]   = 128'hFFFF;
      end else begin
        start_s[0] = 1'b0;
      end
      @(negedge clk);
    end
    check("a55a_bits", 0, 32'(seen), 32'h000D2AB4);
    check("a55a_busy_len", 0, busy_n, 80);
    check("a55a_done_cycle", 0, done_at, 81);
    check("a55a_done_count", 0, done_cnt[0] - d0, 1);

    // Back-to-back: new start in the done cycle.
    pulse_start(0, 128'($urandom_range(0, 65535)));
    wait_done(0, 100);
    din_s[0]   = 128'h1234;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    check("b2b_tx_start", 0, 32'(tx_w[0]), 32'd0);
    check("b2b_busy", 0, 32'(busy_w[0]), 32'd1);
    wait_done(0, 100);
    @(negedge clk);

    // Reset in cycle 30 of a frame.
    pulse_start(0, 128'($urandom_range(0, 65535)));
    repeat (29) @(negedge clk);
    d0 = done_cnt[0];
    rst_s[0] = 1'b1;
    @(negedge clk);
    check("abort_tx", 0, 32'(tx_w[0]), 32'd1);
    check("abort_busy", 0, 32'(busy_w[0]), 32'd0);
    check("abort_done", 0, 32'(done_w[0]), 32'd0);
    rst_s[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", 0, done_cnt[0] - d0, 0);
    pulse_start(0, 128'($urandom_range(0, 65535)));
    wait_done(0, 100);
    @(negedge clk);

    // Smallest frame: one 8'h00 byte at two cycles per bit.
    run_frame(1, 128'h00, 25, busy_n, done_at);
    check("min_busy_len", 1, busy_n, 20);
    check("min_done_cycle", 1, done_at, 21);
    check("min_data_bit", 1, 32'(tx_log[5]), 32'd0);

    // 16-byte ramp (byte b holds value b): byte 0 first, byte 1 LSB is 1.
    for (int b = 0; b < 16; b++) ramp[8*b +: 8] = 8'(b);
    run_frame(3, ramp, 490, busy_n, done_at);
    check("wide_busy_len", 3, busy_n, 480);
    check("wide_done_cycle", 3, done_at, 481);
    check("wide_byte0_bit0", 3, 32'(tx_log[5]), 32'd0);
    check("wide_byte1_bit0", 3, 32'(tx_log[35]), 32'd1);
    check("wide_byte1_start", 3, 32'(tx_log[32]), 32'd0);

    // Timer stage: a start pulse every 512 cycles, 160-cycle frames.
    d0 = done_cnt[2];
    for (int p = 0; p < 5; p++) begin
      pulse_start(2, {$urandom, $urandom, $urandom, $urandom});
      check("timer_accept", 2, 32'(busy_w[2]), 32'd1);
      repeat (511) @(negedge clk);
    end
    check("timer_done_count", 2, done_cnt[2] - d0, 5);

    // Random traffic on lanes 0, 1 and 3, including requests while busy.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < LANES; k++) begin
        if (k != 2) begin
          start_s[k] = ($urandom_range(0, 99) < 4);
          din_s[k]   = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      if ($urandom_range(0, 999) == 0) rst_s[0] = 1'b1;
      else                             rst_s[0] = 1'b0;
      @(negedge clk);
    end
    start_s = '0;
    rst_s   = '0;
    repeat (600) @(negedge clk);
    for (int k = 0; k < LANES; k++) check("end_idle", k, 32'(busy_w[k]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
